// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding, load-use bubble
// insertion, branch flush and downstream hold.
module id_ex_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_IDX_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [REG_IDX_W-1:0]  rn_idx,
  input  logic [REG_IDX_W-1:0]  rm_idx,
  input  logic                  rm_used,
  input  logic [REG_IDX_W-1:0]  rd_idx,
  input  logic [DATA_WIDTH-1:0] rn_data,
  input  logic [DATA_WIDTH-1:0] rm_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  use_imm,
  input  logic [2:0]            cntrl_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  set_flags_in,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [REG_IDX_W-1:0]  mem_rd,
  input  logic                  mem_reg_write,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [2:0]            cntrl,
  output logic [REG_IDX_W-1:0]  ex_rd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_set_flags,
  output logic [DATA_WIDTH-1:0] ex_store_data
);

  localparam logic [REG_IDX_W-1:0] XZR = '1;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            cntrl;
    logic [REG_IDX_W-1:0]  rd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  set_flags;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] store;
  } stage_t;

  localparam stage_t BUBBLE = '{
    valid: 1'b0, cntrl: 3'b000, rd: XZR, mem_read: 1'b0, mem_write: 1'b0,
    reg_write: 1'b0, set_flags: 1'b0, a: '0, b: '0, store: '0
  };

  stage_t stage_q, stage_d;
  logic   load_use;
  logic   ex_fwd_ok;
  logic [DATA_WIDTH-1:0] rn_fwd, rm_fwd;

  // A load's value is not available in EX, so only non-load EX results forward.
  assign ex_fwd_ok = stage_q.valid & stage_q.reg_write & ~stage_q.mem_read;

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_IDX_W-1:0]  idx,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic                  ex_ok,
    input logic [REG_IDX_W-1:0]  ex_idx,
    input logic [DATA_WIDTH-1:0] ex_val,
    input logic                  mem_ok,
    input logic [REG_IDX_W-1:0]  mem_idx,
    input logic [DATA_WIDTH-1:0] mem_val,
    input logic                  wb_ok,
    input logic [REG_IDX_W-1:0]  wb_idx,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    if (idx == XZR)                      return rf_val;
    else if (ex_ok  && ex_idx  == idx)   return ex_val;
    else if (mem_ok && mem_idx == idx)   return mem_val;
    else if (wb_ok  && wb_idx  == idx)   return wb_val;
    else                                 return rf_val;
  endfunction

  assign rn_fwd = fwd(rn_idx, rn_data, ex_fwd_ok, stage_q.rd, ex_result,
                      mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result);
  assign rm_fwd = fwd(rm_idx, rm_data, ex_fwd_ok, stage_q.rd, ex_result,
                      mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result);

  assign load_use = in_valid & stage_q.valid & stage_q.mem_read & (stage_q.rd != XZR) &
                    ((rn_idx == stage_q.rd) | (rm_used & (rm_idx == stage_q.rd)));

  assign stall = hold | (load_use & ~flush);

  always_comb begin
    // NOTE: default to the current contents first so every path assigns stage_d and no latch is inferred.
    stage_d = stage_q;
    if (flush) begin
      stage_d = BUBBLE;
    end else if (hold) begin
      stage_d = stage_q;
    end else if (load_use || !in_valid) begin
      stage_d = BUBBLE;
    end else begin
      stage_d.valid     = 1'b1;
      stage_d.cntrl     = cntrl_in;
      stage_d.rd        = rd_idx;
      stage_d.mem_read  = mem_read_in;
      stage_d.mem_write = mem_write_in;
      stage_d.reg_write = reg_write_in;
      stage_d.set_flags = set_flags_in;
      stage_d.a         = rn_fwd;
      stage_d.b         = use_imm ? imm : rm_fwd;
      stage_d.store     = rm_fwd;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= BUBBLE;
    else       stage_q <= stage_d;
  end

  assign ex_valid      = stage_q.valid;
  assign A             = stage_q.a;
  assign B             = stage_q.b;
  assign cntrl         = stage_q.cntrl;
  assign ex_rd         = stage_q.rd;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_set_flags  = stage_q.set_flags;
  assign ex_store_data = stage_q.store;

endmodule
